fifo_wr_ctrl: RTL and testbench



---
 rtl/fifo_wr_ctrl.sv | 112 +++++++++++
 tb/tb_fifo_wr_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// Write-side FIFO controller: waits for empty, settles, then writes one counting burst.
// Optional macro FIFO_WR_PAUSE_EN adds a pause input that stalls the burst in place.
module fifo_wr_ctrl #(
    parameter int DATA_W     = 8,
    parameter int BURST_LEN  = 256,
    parameter int SETTLE_CYC = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wrempty,
    input  logic              wrfull,
`ifdef FIFO_WR_PAUSE_EN
    input  logic              pause,
`endif
    output logic              wrreq,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic [15:0]       burst_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WRITE
    } state_t;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [15:0] LAST_WORD   = 16'(BURST_LEN - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_wait_cnt;
    logic [7:0]          w_wait_nxt;
    logic [15:0]         r_word_cnt;
    logic [15:0]         w_word_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [15:0]         r_burst_cnt;
    logic [15:0]         w_burst_nxt;
    logic                w_pause;
    logic                w_wrreq;

`ifdef FIFO_WR_PAUSE_EN
    assign w_pause = pause;
`else
    assign w_pause = 1'b0;
`endif

    // Full blocks the write in the same cycle it is seen
    assign w_wrreq   = (r_state == S_WRITE) && !wrfull && !w_pause;
    assign wrreq     = w_wrreq;
    assign data      = r_data;
    assign busy      = (r_state != S_IDLE);
    assign burst_cnt = r_burst_cnt;

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_word_nxt  = r_word_cnt;
        w_data_nxt  = r_data;
        w_burst_nxt = r_burst_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (wrempty) begin
                    w_state_nxt = S_WAIT;
                    w_wait_nxt  = 8'd0;
                end
            end
            S_WAIT: begin
                w_wait_nxt = r_wait_cnt + 8'd1;
                if (r_wait_cnt == SETTLE_LAST) begin
                    w_state_nxt = S_WRITE;
                    w_data_nxt  = '0;
                    w_word_nxt  = 16'd0;
                end
            end
            S_WRITE: begin
                if (w_wrreq) begin
                    w_data_nxt = r_data + 1'b1;
                    w_word_nxt = r_word_cnt + 16'd1;
                    if (r_word_cnt == LAST_WORD) begin
                        w_state_nxt = S_IDLE;
                        w_burst_nxt = r_burst_cnt + 16'd1;
                    end
                end else if (wrfull) begin
                    w_state_nxt = S_IDLE;
                    w_burst_nxt = r_burst_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_word_cnt  <= 16'd0;
            r_data      <= '0;
            r_burst_cnt <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_word_cnt  <= w_word_nxt;
            r_data      <= w_data_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: default instance plus a BURST_LEN=300 instance.
// Pause scenario runs only when FIFO_WR_PAUSE_EN is defined.
module tb_fifo_wr_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wrempty = 1'b0;
    logic        wrfull = 1'b0;
`ifdef FIFO_WR_PAUSE_EN
    logic        pause = 1'b0;
`endif
    logic        wrreq;
    logic        busy;
    logic [7:0]  data;
    logic [15:0] burst_cnt;
    logic        wrempty_b = 1'b0;
    logic        wrreq_b;
    logic        busy_b;
    logic [7:0]  data_b;
    logic [15:0] burst_cnt_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int q[$];
    int qb[$];
    int gaps[$];
    int wr_count = 0;
    int wr_b = 0;
    int first_acc = -1;
    int last_acc = 0;
    int last_b = -1;
    bit have_last = 0;
    int t0;

    fifo_wr_ctrl u_dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .wrempty   (wrempty),
        .wrfull    (wrfull),
`ifdef FIFO_WR_PAUSE_EN
        .pause     (pause),
`endif
        .wrreq     (wrreq),
        .data      (data),
        .busy      (busy),
        .burst_cnt (burst_cnt)
    );

    fifo_wr_ctrl #(.DATA_W(8), .BURST_LEN(300), .SETTLE_CYC(10)) u_dut_b (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .wrempty   (wrempty_b),
        .wrfull    (wrfull),
`ifdef FIFO_WR_PAUSE_EN
        .pause     (pause),
`endif
        .wrreq     (wrreq_b),
        .data      (data_b),
        .busy      (busy_b),
        .burst_cnt (burst_cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every negedge with wrreq high is a word accepted on the next posedge
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                wr_count = 0;
                wr_b = 0;
                have_last = 0;
                first_acc = -1;
                last_b = -1;
            end else begin
                if (wrreq) begin
                    checks++;
                    if (q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write actual=%0d required=none", data);
                    end else begin
                        e = q.pop_front();
                        if (data !== e[7:0]) begin
                            failures++;
                            $display("FAIL data_word%0d actual=%0d required=%0d",
                                     wr_count, data, e[7:0]);
                        end
                    end
                    if (have_last && (cyc + 1 - last_acc) != 1)
                        gaps.push_back(cyc + 1 - last_acc);
                    if (first_acc < 0) first_acc = cyc + 1;
                    last_acc = cyc + 1;
                    have_last = 1;
                    wr_count++;
                end
                if (wrreq_b) begin
                    checks++;
                    if (qb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_write_b actual=%0d required=none", data_b);
                    end else begin
                        e = qb.pop_front();
                        if (data_b !== e[7:0]) begin
                            failures++;
                            $display("FAIL data_b_word%0d actual=%0d required=%0d",
                                     wr_b, data_b, e[7:0]);
                        end
                    end
                    last_b = int'(data_b);
                    wr_b++;
                end
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        q.delete();
        qb.delete();
        gaps.delete();
        repeat (2) tick();
    endtask

    task automatic release_rst(output int edge0);
        @(negedge clk);
        rst_n = 1'b1;
        edge0 = cyc + 1;
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) q.push_back(i % 256);
    endtask

    task automatic wait_wr(input int n, input int lim, input string nm);
        int k = 0;
        while (wr_count < n && k < lim) begin
            tick();
            k++;
        end
        if (wr_count < n) chk(nm, wr_count, n);
    endtask

    task automatic wait_burst(input int n, input int lim, input string nm);
        int k = 0;
        while (burst_cnt != 16'(n) && k < lim) begin
            tick();
            k++;
        end
        chk(nm, int'(burst_cnt), n);
    endtask

    initial begin
        // 1: reset state, settle latency, full 256-word burst
        wrempty = 1'b1;
        do_reset();
        chk("rst_wrreq", int'(wrreq), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_burst_cnt", int'(burst_cnt), 0);
        push_burst(256);
        release_rst(t0);
        wait_wr(1, 40, "t1_first_write_timeout");
        wrempty = 1'b0;
        wait_burst(1, 400, "t1_burst_cnt");
        chk("t1_latency", first_acc - t0, 11);
        chk("t1_words", wr_count, 256);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_gaps", gaps.size(), 0);
        chk("t1_queue_left", q.size(), 0);

        // 2: full after 100 words stops the burst in the same cycle
        do_reset();
        push_burst(100);
        wrempty = 1'b1;
        release_rst(t0);
        wait_wr(1, 40, "t2_first_write_timeout");
        wrempty = 1'b0;
        wait_wr(100, 200, "t2_wr100_timeout");
        wrfull = 1'b1;
        #1;
        chk("t2_wrreq_on_full", int'(wrreq), 0);
        wait_burst(1, 20, "t2_burst_cnt");
        chk("t2_busy_after", int'(busy), 0);
        wrfull = 1'b0;
        repeat (3) tick();
        chk("t2_words", wr_count, 100);
        chk("t2_queue_left", q.size(), 0);

        // 3: wrempty held high gives back-to-back bursts
        do_reset();
        push_burst(256);
        push_burst(256);
        push_burst(256);
        wrempty = 1'b1;
        release_rst(t0);
        wait_burst(1, 400, "t3_burst1");
        chk("t3_busy_b1", int'(busy), 0);
        wait_burst(2, 400, "t3_burst2");
        wait_wr(513, 100, "t3_wr513_timeout");
        wrempty = 1'b0;
        wait_burst(3, 400, "t3_burst3");
        repeat (15) tick();
        chk("t3_words", wr_count, 768);
        chk("t3_busy_idle", int'(busy), 0);
        chk("t3_gap_count", gaps.size(), 2);
        if (gaps.size() == 2) begin
            chk("t3_gap1", gaps[0], 12);
            chk("t3_gap2", gaps[1], 12);
        end

        // 4: BURST_LEN=300 wraps data within the burst
        do_reset();
        for (int i = 0; i < 300; i++) qb.push_back(i % 256);
        wrempty_b = 1'b1;
        release_rst(t0);
        begin
            int k = 0;
            while (wr_b < 1 && k < 40) begin
                tick();
                k++;
            end
            wrempty_b = 1'b0;
            k = 0;
            while (burst_cnt_b != 16'd1 && k < 400) begin
                tick();
                k++;
            end
        end
        chk("t4_burst_cnt", int'(burst_cnt_b), 1);
        chk("t4_words", wr_b, 300);
        chk("t4_last_data", last_b, 43);
        chk("t4_busy_after", int'(busy_b), 0);
        chk("t4_queue_left", qb.size(), 0);

        // 5: async reset mid-burst, then a clean restart from 0
        do_reset();
        push_burst(256);
        wrempty = 1'b1;
        release_rst(t0);
        wait_wr(1, 40, "t5_first_write_timeout");
        wrempty = 1'b0;
        wait_wr(51, 100, "t5_wr51_timeout");
        chk("t5_wrreq_before_rst", int'(wrreq), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_wrreq", int'(wrreq), 0);
        chk("t5_async_data", int'(data), 0);
        chk("t5_async_busy", int'(busy), 0);
        q.delete();
        gaps.delete();
        tick();
        chk("t5_rst_burst_cnt", int'(burst_cnt), 0);
        push_burst(256);
        wrempty = 1'b1;
        release_rst(t0);
        wait_wr(1, 40, "t5_restart_timeout");
        wrempty = 1'b0;
        chk("t5_restart_latency", first_acc - t0, 11);
        wait_burst(1, 400, "t5_burst_cnt");
        chk("t5_words", wr_count, 256);
        chk("t5_queue_left", q.size(), 0);

`ifdef FIFO_WR_PAUSE_EN
        // 6: pause for 5 cycles after word 20
        do_reset();
        push_burst(256);
        wrempty = 1'b1;
        release_rst(t0);
        wait_wr(1, 40, "t6_first_write_timeout");
        wrempty = 1'b0;
        wait_wr(21, 100, "t6_wr21_timeout");
        pause = 1'b1;
        #1;
        chk("t6_wrreq_paused", int'(wrreq), 0);
        repeat (5) tick();
        chk("t6_busy_paused", int'(busy), 1);
        chk("t6_words_paused", wr_count, 21);
        pause = 1'b0;
        wait_burst(1, 400, "t6_burst_cnt");
        chk("t6_words", wr_count, 256);
        chk("t6_gap_count", gaps.size(), 1);
        if (gaps.size() == 1) chk("t6_gap", gaps[0], 6);
        chk("t6_queue_left", q.size(), 0);
`endif

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
